// File: rtl/axis_rx_msix_decoder.sv
// Splits DM_INTR interrupt headers off an inbound TLP stream into an MSI-X vector FIFO;
// all other packets pass through untouched. Optional function filter: MSIX_RX_FUNC_FILTER_EN.

package pcie_ss_hdr_pkg;
  localparam logic [7:0] DM_INTR = 8'h30;

  typedef struct packed {
    logic [127:0] rsvd3;
    logic [47:0]  rsvd2;
    logic [15:0]  vector_num;
    logic [10:0]  vf_num;
    logic         vf_active;
    logic [2:0]   pf_num;
    logic [16:0]  rsvd1;
    logic [23:0]  rsvd0;
    logic [7:0]   fmt_type;
  } PCIe_IntrHdr_t;
endpackage

interface pcie_ss_axis_if #(
  parameter int DATA_W = 256,
  parameter int USER_W = 10
);
  logic                tvalid;
  logic                tready;
  logic                tlast;
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic [USER_W-1:0]   tuser_vendor;

  modport source (output tvalid, tlast, tdata, tkeep, tuser_vendor, input tready);
  modport sink   (input tvalid, tlast, tdata, tkeep, tuser_vendor, output tready);
endinterface

module axis_rx_msix_decoder
  import pcie_ss_hdr_pkg::*;
#(
  parameter int PF_NUM     = 0,
  parameter int VF_NUM     = 0,
  parameter int VF_ACTIVE  = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pcie_ss_axis_if.sink          axis_rx_if,
  pcie_ss_axis_if.source        axis_fwd_if,
  output logic                  msix_valid,
  output logic [15:0]           msix_num,
  input  logic                  msix_ready,
  output logic [15:0]           msix_drop_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_SOP, ST_FWD, ST_CONSUME} state_t;

  state_t        r_state, w_state_nxt;
  PCIe_IntrHdr_t w_hdr;
  logic          w_is_intr, w_pass, w_rdy, w_fvld, w_acc, w_push, w_pop;
  logic          w_unused_hdr;
  logic [15:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count, w_count_nxt;
  logic          r_full;

  assign w_hdr        = PCIe_IntrHdr_t'(axis_rx_if.tdata[$bits(PCIe_IntrHdr_t)-1:0]);
  assign w_unused_hdr = ^w_hdr;
  assign w_is_intr    = axis_rx_if.tuser_vendor[0] && (w_hdr.fmt_type == DM_INTR);

`ifdef MSIX_RX_FUNC_FILTER_EN
  logic [15:0] r_drop_cnt;

  assign w_pass = (w_hdr.pf_num == 3'(PF_NUM)) && (w_hdr.vf_num == 11'(VF_NUM)) &&
                  (w_hdr.vf_active == 1'(VF_ACTIVE));

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_drop_cnt <= '0;
    else if (w_acc && r_state == ST_SOP && w_is_intr && !w_pass && r_drop_cnt != 16'hFFFF)
      r_drop_cnt <= r_drop_cnt + 16'd1;
  end

  assign msix_drop_cnt = r_drop_cnt;
`else
  assign w_pass        = 1'b1;
  assign msix_drop_cnt = '0;
`endif

  // Ready/valid steering and packet-boundary tracking; both outputs held low in reset.
  always_comb begin
    w_state_nxt = r_state;
    w_rdy       = 1'b0;
    w_fvld      = 1'b0;
    w_acc       = 1'b0;
    if (rst_n) begin
      unique case (r_state)
        ST_SOP: begin
          if (w_is_intr) begin
            // Filtered-out interrupts are always swallowed, even with a full FIFO.
            w_rdy = w_pass ? !r_full : 1'b1;
          end else begin
            w_rdy  = axis_fwd_if.tready;
            w_fvld = axis_rx_if.tvalid;
          end
        end
        ST_FWD: begin
          w_rdy  = axis_fwd_if.tready;
          w_fvld = axis_rx_if.tvalid;
        end
        ST_CONSUME: w_rdy = 1'b1;
        default: w_rdy = 1'b0;
      endcase
      w_acc = axis_rx_if.tvalid && w_rdy;
      if (w_acc) begin
        if (r_state == ST_SOP) begin
          if (!axis_rx_if.tlast) w_state_nxt = w_is_intr ? ST_CONSUME : ST_FWD;
        end else if (axis_rx_if.tlast) begin
          w_state_nxt = ST_SOP;
        end
      end
    end
  end

  assign axis_rx_if.tready         = w_rdy;
  assign axis_fwd_if.tvalid        = w_fvld;
  assign axis_fwd_if.tdata         = axis_rx_if.tdata;
  assign axis_fwd_if.tkeep         = axis_rx_if.tkeep;
  assign axis_fwd_if.tlast         = axis_rx_if.tlast;
  assign axis_fwd_if.tuser_vendor  = axis_rx_if.tuser_vendor;

  assign w_push = w_acc && (r_state == ST_SOP) && w_is_intr && w_pass;
  assign w_pop  = msix_valid && msix_ready;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + 1'b1;
    else if (!w_push && w_pop) w_count_nxt = r_count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_SOP;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == (AW+1)'(FIFO_DEPTH));
    end
  end

  // Vector storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_hdr.vector_num;
  end

  assign msix_valid = (r_count != '0);
  assign msix_num   = r_mem[r_rptr];
endmodule

// File: tb/tb_axis_rx_msix_decoder.sv
// Bench for axis_rx_msix_decoder: directed scenarios plus randomized packet mix against a packet-level model.
module tb_axis_rx_msix_decoder;
  import pcie_ss_hdr_pkg::*;

  typedef struct packed {
    logic         last;
    logic [9:0]   user;
    logic [31:0]  keep;
    logic [255:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        msix_ready, msix_valid;
  logic [15:0] msix_num, msix_drop_cnt;
  int          fwd_mode, msix_mode;
  logic        rnd_f, rnd_m;
  int          n_pass = 0, n_total = 0;
  int          valid_cycles;
  int          exp_drop;
  beat_t       fwd_obs[$], exp_fwd[$];
  logic [15:0] msix_obs[$], exp_msix[$];

  always #5 clk = ~clk;

  pcie_ss_axis_if rx_if();
  pcie_ss_axis_if fwd_if();

  assign fwd_if.tready = (fwd_mode == 2) ? rnd_f : (fwd_mode == 1);
  assign msix_ready    = (msix_mode == 2) ? rnd_m : (msix_mode == 1);

  axis_rx_msix_decoder #(.PF_NUM(0), .VF_NUM(0), .VF_ACTIVE(0), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .axis_rx_if(rx_if), .axis_fwd_if(fwd_if),
    .msix_valid(msix_valid), .msix_num(msix_num), .msix_ready(msix_ready),
    .msix_drop_cnt(msix_drop_cnt));

  initial begin
    rnd_f = 1'b1;
    rnd_m = 1'b1;
    forever begin
      @(posedge clk); #1;
      rnd_f = ($urandom_range(0, 3) != 0);
      rnd_m = 1'($urandom_range(0, 1));
    end
  end

  // Handshakes are judged at the falling edge; inputs only change just after the rising edge.
  always @(negedge clk) begin
    if (fwd_if.tvalid === 1'b1 && fwd_if.tready === 1'b1)
      fwd_obs.push_back({fwd_if.tlast, fwd_if.tuser_vendor, fwd_if.tkeep, fwd_if.tdata});
    if (msix_valid === 1'b1 && msix_ready === 1'b1) msix_obs.push_back(msix_num);
    if (msix_valid === 1'b1) valid_cycles++;
  end

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic beat_t mk_intr(input logic [15:0] vec, input logic [2:0] pf, input bit last);
    PCIe_IntrHdr_t h;
    beat_t b;
    h            = PCIe_IntrHdr_t'(rnd256());
    h.fmt_type   = DM_INTR;
    h.vector_num = vec;
    h.pf_num     = pf;
    h.vf_num     = '0;
    h.vf_active  = 1'b0;
    b.data = h;
    b.keep = '1;
    b.user = 10'($urandom) | 10'h1;
    b.last = last;
    return b;
  endfunction

  function automatic beat_t mk_data(input bit u0, input logic [7:0] fmt, input bit last);
    beat_t b;
    b.data      = rnd256();
    b.data[7:0] = fmt;
    b.keep      = $urandom;
    b.user      = 10'($urandom);
    b.user[0]   = u0;
    b.last      = last;
    return b;
  endfunction

  // Packet-level reference: interrupts become vectors, everything else is forwarded verbatim.
  function automatic void model_pkt(input beat_t p[$]);
    PCIe_IntrHdr_t h;
    bit intr, ok;
    h    = PCIe_IntrHdr_t'(p[0].data);
    intr = p[0].user[0] && (h.fmt_type == DM_INTR);
    ok   = 1'b1;
`ifdef MSIX_RX_FUNC_FILTER_EN
    ok = (h.pf_num == 3'd0) && (h.vf_num == 11'd0) && (h.vf_active == 1'b0);
`endif
    if (!intr) foreach (p[i]) exp_fwd.push_back(p[i]);
    else if (ok) exp_msix.push_back(h.vector_num);
    else exp_drop++;
  endfunction

  task automatic drive_beat(input beat_t b);
    rx_if.tvalid       = 1'b1;
    rx_if.tdata        = b.data;
    rx_if.tkeep        = b.keep;
    rx_if.tuser_vendor = b.user;
    rx_if.tlast        = b.last;
  endtask

  task automatic send_beat(input beat_t b, output int waits);
    drive_beat(b);
    waits = 0;
    @(negedge clk);
    while (rx_if.tready !== 1'b1 && waits < 1000) begin
      @(negedge clk);
      waits++;
    end
    if (rx_if.tready !== 1'b1) begin
      n_total++;
      $display("FAIL send_beat_timeout: tready=%b after %0d cycles, want 1", rx_if.tready, waits);
    end
    @(posedge clk); #1;
    rx_if.tvalid = 1'b0;
  endtask

  task automatic send_pkt(input beat_t p[$], output int stalls);
    int w;
    stalls = 0;
    foreach (p[i]) begin
      send_beat(p[i], w);
      stalls += w;
    end
  endtask

  task automatic clear_obs();
    fwd_obs.delete(); exp_fwd.delete(); msix_obs.delete(); exp_msix.delete();
    valid_cycles = 0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((msix_obs.size() < exp_msix.size() || fwd_obs.size() < exp_fwd.size()) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rx_if.tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_drop = 0;
    clear_obs();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_beat(mk_data(1'b0, 8'h60, 1'b1));
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++; if (rx_if.tready !== 1'b0) $display("FAIL reset_tready: got %b, want 0", rx_if.tready); else n_pass++;
    n_total++; if (fwd_if.tvalid !== 1'b0) $display("FAIL reset_fwd_tvalid: got %b, want 0", fwd_if.tvalid); else n_pass++;
    n_total++; if (msix_valid !== 1'b0) $display("FAIL reset_msix_valid: got %b, want 0", msix_valid); else n_pass++;
    n_total++; if (msix_drop_cnt !== 16'h0) $display("FAIL reset_drop_cnt: got %h, want 0000", msix_drop_cnt); else n_pass++;
    @(posedge clk); #1;
    rx_if.tvalid = 1'b0;
    rst_n = 1'b1;
    exp_drop = 0;
    clear_obs();
  endtask

  task automatic test_single_intr();
    beat_t p[$];
    int st;
    clear_obs();
    fwd_mode = 1; msix_mode = 1;
    p.push_back(mk_intr(16'h0005, 3'd0, 1'b1));
    model_pkt(p);
    send_pkt(p, st);
    wait_drain();
    n_total++; if (msix_obs.size() != 1 || msix_obs[0] !== 16'h0005)
      $display("FAIL single_vector: got %0d vectors (first %h), want 1 x 0005", msix_obs.size(), (msix_obs.size() > 0) ? msix_obs[0] : 16'hxxxx);
    else n_pass++;
    n_total++; if (valid_cycles != 1) $display("FAIL single_valid_cycles: got %0d, want 1", valid_cycles); else n_pass++;
    n_total++; if (fwd_obs.size() != 0) $display("FAIL single_no_fwd: got %0d beats, want 0", fwd_obs.size()); else n_pass++;
  endtask

  task automatic test_interleave();
    beat_t p[$];
    int st, stalls;
    clear_obs();
    stalls = 0;
    fwd_mode = 1; msix_mode = 1;
    p.delete(); p.push_back(mk_intr(16'd7, 3'd0, 1'b1)); model_pkt(p); send_pkt(p, st); stalls += st;
    p.delete();
    p.push_back(mk_data(1'b0, 8'h60, 1'b0));
    p.push_back(mk_data(1'b0, 8'h00, 1'b0));
    p.push_back(mk_data(1'b1, 8'h00, 1'b1));
    model_pkt(p); send_pkt(p, st); stalls += st;
    p.delete(); p.push_back(mk_intr(16'd9, 3'd0, 1'b1)); model_pkt(p); send_pkt(p, st); stalls += st;
    wait_drain();
    n_total++; if (fwd_obs.size() != 3) $display("FAIL interleave_fwd_count: got %0d, want 3", fwd_obs.size()); else n_pass++;
    for (int i = 0; i < fwd_obs.size() && i < exp_fwd.size(); i++) begin
      n_total++; if (fwd_obs[i] !== exp_fwd[i]) $display("FAIL interleave_fwd_beat%0d: got %h, want %h", i, fwd_obs[i][63:0], exp_fwd[i][63:0]); else n_pass++;
    end
    n_total++; if (msix_obs.size() != 2 || msix_obs[0] !== 16'd7 || msix_obs[1] !== 16'd9)
      $display("FAIL interleave_vectors: got %0d vectors, want 7 then 9", msix_obs.size());
    else n_pass++;
    n_total++; if (stalls != 0) $display("FAIL interleave_stalls: got %0d, want 0", stalls); else n_pass++;
  endtask

  task automatic test_no_filter_or_filter();
    beat_t p[$];
    int st;
    do_reset();
    fwd_mode = 1; msix_mode = 1;
    p.push_back(mk_intr(16'h0042, 3'd1, 1'b1));
    model_pkt(p);
    send_pkt(p, st);
    wait_drain();
`ifdef MSIX_RX_FUNC_FILTER_EN
    n_total++; if (msix_obs.size() != 0) $display("FAIL filter_pf_vector: got %0d vectors, want 0", msix_obs.size()); else n_pass++;
    n_total++; if (msix_drop_cnt !== 16'd1) $display("FAIL filter_pf_drop: got %0d, want 1", msix_drop_cnt); else n_pass++;
    // A mismatching interrupt must still be swallowed while the FIFO is full.
    msix_mode = 0;
    for (int v = 0; v < 16; v++) begin
      p.delete(); p.push_back(mk_intr(16'(v), 3'd0, 1'b1)); model_pkt(p); send_pkt(p, st);
    end
    p.delete(); p.push_back(mk_intr(16'h0099, 3'd2, 1'b1)); model_pkt(p); send_pkt(p, st);
    n_total++; if (st != 0) $display("FAIL filter_full_stall: got %0d waits, want 0", st); else n_pass++;
    n_total++; if (msix_drop_cnt !== 16'd2) $display("FAIL filter_full_drop: got %0d, want 2", msix_drop_cnt); else n_pass++;
    msix_mode = 1;
    wait_drain();
    n_total++; if (msix_obs.size() != 16) $display("FAIL filter_drain: got %0d vectors, want 16", msix_obs.size()); else n_pass++;
    clear_obs();
    drive_beat(mk_intr(16'h0077, 3'd1, 1'b1));
    repeat (65540) @(posedge clk);
    #1;
    rx_if.tvalid = 1'b0;
    @(negedge clk);
    n_total++; if (msix_drop_cnt !== 16'hFFFF) $display("FAIL filter_saturate: got %h, want FFFF", msix_drop_cnt); else n_pass++;
    n_total++; if (msix_valid !== 1'b0) $display("FAIL filter_sat_valid: got %b, want 0", msix_valid); else n_pass++;
`else
    n_total++; if (msix_obs.size() != 1 || msix_obs[0] !== 16'h0042)
      $display("FAIL nofilter_vector: got %0d vectors, want 1 x 0042", msix_obs.size());
    else n_pass++;
    n_total++; if (msix_drop_cnt !== 16'd0) $display("FAIL nofilter_drop: got %0d, want 0", msix_drop_cnt); else n_pass++;
`endif
  endtask

  task automatic test_fifo_full();
    beat_t p[$];
    int st, n;
    bit blocked;
    clear_obs();
    fwd_mode = 1; msix_mode = 0;
    for (int v = 0; v < 16; v++) begin
      p.delete(); p.push_back(mk_intr(16'(v), 3'd0, 1'b1)); model_pkt(p); send_pkt(p, st);
    end
    @(negedge clk);
    n_total++; if (msix_valid !== 1'b1 || msix_num !== 16'd0) $display("FAIL full_head: got valid=%b num=%0d, want 1/0", msix_valid, msix_num); else n_pass++;
    p.delete(); p.push_back(mk_intr(16'd16, 3'd0, 1'b1));
    @(posedge clk); #1;
    drive_beat(p[0]);
    blocked = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (rx_if.tready !== 1'b0) blocked = 1'b0;
    end
    n_total++; if (!blocked) $display("FAIL full_backpressure: tready seen 1, want 0 while full"); else n_pass++;
    @(posedge clk); #1;
    msix_mode = 1;
    @(posedge clk); #1;
    msix_mode = 0;
    n = 0;
    @(negedge clk);
    while (rx_if.tready !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    n_total++; if (rx_if.tready !== 1'b1) $display("FAIL full_accept_after_pop: tready=%b, want 1", rx_if.tready); else n_pass++;
    @(posedge clk); #1;
    rx_if.tvalid = 1'b0;
    model_pkt(p);
    msix_mode = 1;
    wait_drain();
    n_total++; if (msix_obs.size() != 17) $display("FAIL full_count: got %0d, want 17", msix_obs.size()); else n_pass++;
    for (int i = 0; i < msix_obs.size() && i < exp_msix.size(); i++) begin
      n_total++; if (msix_obs[i] !== exp_msix[i]) $display("FAIL full_order%0d: got %0d, want %0d", i, msix_obs[i], exp_msix[i]); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int w;
    clear_obs();
    fwd_mode = 1; msix_mode = 0;
    send_beat(mk_intr(16'h1234, 3'd0, 1'b1), w);
    msix_mode = 1;
    send_beat(mk_intr(16'hBEEF, 3'd0, 1'b1), w);
    msix_mode = 0;
    @(negedge clk);
    n_total++; if (msix_valid !== 1'b1 || msix_num !== 16'hBEEF) $display("FAIL pushpop_next: got valid=%b num=%h, want 1/BEEF", msix_valid, msix_num); else n_pass++;
    n_total++; if (msix_obs.size() != 1 || msix_obs[0] !== 16'h1234) $display("FAIL pushpop_popped: got %0d vectors, want 1 x 1234", msix_obs.size()); else n_pass++;
    @(posedge clk); #1;
    msix_mode = 1;
    @(posedge clk); #1;
    msix_mode = 0;
    @(negedge clk);
    n_total++; if (msix_valid !== 1'b0) $display("FAIL pushpop_occupancy: valid=%b after one pop, want 0", msix_valid); else n_pass++;
    @(posedge clk); #1;
    msix_mode = 1;
    clear_obs();
  endtask

  task automatic test_reset_midpacket();
    beat_t tlp[$], p[$];
    int w, st;
    clear_obs();
    fwd_mode = 1; msix_mode = 1;
    for (int i = 0; i < 4; i++) tlp.push_back(mk_data(1'b0, 8'h60, i == 3));
    send_beat(tlp[0], w);
    exp_fwd.push_back(tlp[0]);
    drive_beat(tlp[1]);
    rst_n = 1'b0;
    @(negedge clk);
    n_total++; if (rx_if.tready !== 1'b0) $display("FAIL midrst_tready: got %b, want 0", rx_if.tready); else n_pass++;
    n_total++; if (fwd_if.tvalid !== 1'b0) $display("FAIL midrst_fwd_tvalid: got %b, want 0", fwd_if.tvalid); else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rx_if.tvalid = 1'b0;
    exp_drop = 0;
    p.push_back(mk_intr(16'd3, 3'd0, 1'b1));
    model_pkt(p);
    send_pkt(p, st);
    wait_drain();
    n_total++; if (msix_drop_cnt !== 16'd0) $display("FAIL midrst_drop: got %0d, want 0", msix_drop_cnt); else n_pass++;
    n_total++; if (fwd_obs.size() != 1 || fwd_obs[0] !== exp_fwd[0]) $display("FAIL midrst_fwd: got %0d beats, want only the pre-reset beat", fwd_obs.size()); else n_pass++;
    n_total++; if (msix_obs.size() != 1 || msix_obs[0] !== 16'd3) $display("FAIL midrst_vector: got %0d vectors, want 1 x 3", msix_obs.size()); else n_pass++;
  endtask

  task automatic test_random();
    beat_t p[$];
    int st, len, kind;
    clear_obs();
    fwd_mode = 2; msix_mode = 2;
    for (int k = 0; k < 60; k++) begin
      p.delete();
      len  = $urandom_range(1, 4);
      kind = $urandom_range(0, 2);
      if (kind == 0)      p.push_back(mk_intr(16'($urandom), 3'($urandom_range(0, 1)), len == 1));
      else if (kind == 1) p.push_back(mk_data(1'b0, DM_INTR, len == 1));
      else                p.push_back(mk_data(1'b1, 8'h60, len == 1));
      for (int j = 1; j < len; j++) p.push_back(mk_data(1'($urandom_range(0, 1)), 8'($urandom), j == len - 1));
      model_pkt(p);
      send_pkt(p, st);
    end
    fwd_mode = 1; msix_mode = 1;
    wait_drain();
    n_total++; if (fwd_obs.size() != exp_fwd.size()) $display("FAIL rand_fwd_count: got %0d, want %0d", fwd_obs.size(), exp_fwd.size()); else n_pass++;
    for (int i = 0; i < fwd_obs.size() && i < exp_fwd.size(); i++) begin
      n_total++; if (fwd_obs[i] !== exp_fwd[i]) $display("FAIL rand_fwd_beat%0d: got %h, want %h", i, fwd_obs[i][63:0], exp_fwd[i][63:0]); else n_pass++;
    end
    n_total++; if (msix_obs.size() != exp_msix.size()) $display("FAIL rand_msix_count: got %0d, want %0d", msix_obs.size(), exp_msix.size()); else n_pass++;
    for (int i = 0; i < msix_obs.size() && i < exp_msix.size(); i++) begin
      n_total++; if (msix_obs[i] !== exp_msix[i]) $display("FAIL rand_vector%0d: got %h, want %h", i, msix_obs[i], exp_msix[i]); else n_pass++;
    end
    n_total++; if (msix_drop_cnt !== 16'(exp_drop)) $display("FAIL rand_drop: got %0d, want %0d", msix_drop_cnt, exp_drop); else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0;
    rx_if.tvalid = 1'b0;
    rx_if.tdata = '0;
    rx_if.tkeep = '0;
    rx_if.tlast = 1'b0;
    rx_if.tuser_vendor = '0;
    fwd_mode = 1;
    msix_mode = 1;
    exp_drop = 0;
    valid_cycles = 0;
    test_reset();
    test_single_intr();
    test_interleave();
    test_fifo_full();
    test_back_to_back();
    test_reset_midpacket();
    test_random();
    test_no_filter_or_filter();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
